// File: rtl/vga_game_pkg.sv
// Shared types and default timing constants for the VGA game logic blocks.
package vga_game_pkg;

  localparam int unsigned H_TOTAL           = 1904;
  localparam int unsigned V_TOTAL           = 932;
  localparam int unsigned WINDOW_CYCLES_DEF = 60000;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WAIT,
    CLOSE
  } sched_state_t;

endpackage

// File: rtl/rr_find_first.sv
// Cyclic first-set search: lowest set bit of vec at or after start, wrapping.
module rr_find_first #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] start,
  output logic          found_c,
  output logic [IW-1:0] idx_c
);

  int unsigned pos;

  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    pos     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(start) + k) % N;
      if (!found_c && vec[IW'(pos)]) begin
        found_c = 1'b1;
        idx_c   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/vblank_update_scheduler.sv
// Grants the vertical-blanking window to game-logic clients one at a time,
// with per-client timeout, a per-frame cycle budget and rotating start priority.
module vblank_update_scheduler
  import vga_game_pkg::*;
#(
  parameter int unsigned N_CLIENTS     = 4,
  parameter int unsigned TIMEOUT       = 4096,
  parameter int unsigned WINDOW_CYCLES = WINDOW_CYCLES_DEF,
  parameter int unsigned FCNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vsync,
  input  logic [N_CLIENTS-1:0] req,
  input  logic [N_CLIENTS-1:0] done,
  input  logic                 err_clr,
  output logic [N_CLIENTS-1:0] grant,
  output logic                 busy,
  output logic [FCNT_W-1:0]    frame_cnt,
  output logic                 overrun,
  output logic [N_CLIENTS-1:0] timeout_err
);

  localparam int unsigned IW    = $clog2(N_CLIENTS);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + 1);

  sched_state_t         state_q, state_d;
  logic                 vsync_q, vsync_d;
  logic [N_CLIENTS-1:0] pending_q, pending_d;
  logic [N_CLIENTS-1:0] grant_q, grant_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 busy_q, busy_d;
  logic [FCNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                 overrun_q, overrun_d;
  logic [N_CLIENTS-1:0] timeout_err_q, timeout_err_d;

  logic                 frame_tick;
  logic                 found_c;
  logic [IW-1:0]        found_idx_c;
  logic [N_CLIENTS-1:0] pend_next;

  rr_find_first #(.N(N_CLIENTS), .IW(IW)) u_find (
    .vec     (pending_q),
    .start   (rr_ptr_q),
    .found_c (found_c),
    .idx_c   (found_idx_c)
  );

  assign frame_tick = vsync & ~vsync_q;

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    vsync_d       = vsync;
    pending_d     = pending_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    to_cnt_d      = to_cnt_q;
    win_cnt_d     = win_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    busy_d        = busy_q;
    frame_cnt_d   = frame_cnt_q;
    overrun_d     = 1'b0;
    timeout_err_d = timeout_err_q;
    pend_next     = pending_q;

    if (err_clr) timeout_err_d = '0;
    if (frame_tick && busy_q) overrun_d = 1'b1;
    if ((state_q == SCAN || state_q == WAIT) && win_cnt_q != '0) begin
      win_cnt_d = win_cnt_q - WIN_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          pending_d   = req;
          frame_cnt_d = frame_cnt_q + FCNT_W'(1);
          win_cnt_d   = WIN_W'(WINDOW_CYCLES - 1);
          busy_d      = 1'b1;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (win_cnt_q == '0) begin
          grant_d   = '0;
          overrun_d = overrun_d | (|pending_q);
          state_d   = CLOSE;
        end else if (found_c) begin
          grant_d  = N_CLIENTS'(1) << found_idx_c;
          gidx_d   = found_idx_c;
          to_cnt_d = '0;
          state_d  = WAIT;
        end else begin
          state_d = CLOSE;
        end
      end
      WAIT: begin
        // done outranks both timeout and window expiry
        if (done[gidx_q]) begin
          pend_next[gidx_q] = 1'b0;
          grant_d           = '0;
          state_d           = SCAN;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          pend_next[gidx_q]     = 1'b0;
          timeout_err_d[gidx_q] = 1'b1;
          grant_d               = '0;
          state_d               = SCAN;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
        if (win_cnt_q == '0) begin
          grant_d   = '0;
          overrun_d = overrun_d | (|pend_next);
          state_d   = CLOSE;
        end
        pending_d = pend_next;
      end
      CLOSE: begin
        rr_ptr_d  = (rr_ptr_q == IW'(N_CLIENTS - 1)) ? '0 : rr_ptr_q + IW'(1);
        pending_d = '0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      vsync_q       <= 1'b0;
      pending_q     <= '0;
      grant_q       <= '0;
      gidx_q        <= '0;
      to_cnt_q      <= '0;
      win_cnt_q     <= '0;
      rr_ptr_q      <= '0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= '0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync_d;
      pending_q     <= pending_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      to_cnt_q      <= to_cnt_d;
      win_cnt_q     <= win_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      busy_q        <= busy_d;
      frame_cnt_q   <= frame_cnt_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_cnt_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Bench for vblank_update_scheduler: frame-level behavioural model checked every
// cycle, plus directed frames with hand-computed grant orders and flag values.
module tb_vblank_update_scheduler;

  localparam int N = 4;
  localparam int T = 16;
  localparam int W = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        err_clr = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  done = '0;
  logic [3:0]  grant, timeout_err;
  logic        busy, overrun;
  logic [15:0] frame_cnt;
  logic [3:0]  grant_w, timeout_err_w;
  logic        busy_w, overrun_w;
  logic [1:0]  frame_cnt_w;

  vblank_update_scheduler #(.N_CLIENTS(N), .TIMEOUT(T), .WINDOW_CYCLES(W), .FCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .req(req), .done(done), .err_clr(err_clr),
    .grant(grant), .busy(busy), .frame_cnt(frame_cnt), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  // narrow frame counter copy so the wrap is reachable in a short run
  vblank_update_scheduler #(.N_CLIENTS(N), .TIMEOUT(T), .WINDOW_CYCLES(W), .FCNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .req(req), .done(done), .err_clr(err_clr),
    .grant(grant_w), .busy(busy_w), .frame_cnt(frame_cnt_w), .overrun(overrun_w),
    .timeout_err(timeout_err_w)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy, m_close, m_vs, m_ovr;
  int          m_cur, m_hold, m_age, m_rr;
  logic [15:0] m_fcnt;
  logic [3:0]  m_pend, m_err;

  function automatic logic [3:0] m_grant();
    if (m_cur < 0) return 4'b0000;
    return 4'(1 << m_cur);
  endfunction

  task automatic model_step();
    bit tick, last;
    int f;
    tick = vsync && !m_vs;
    m_vs = vsync;
    m_ovr = 1'b0;
    if (err_clr) m_err = '0;
    if (!m_busy) begin
      if (tick) begin
        m_pend = req; m_fcnt = m_fcnt + 16'd1; m_busy = 1'b1;
        m_age = 0; m_cur = -1; m_close = 1'b0;
      end
    end else begin
      if (tick) m_ovr = 1'b1;
      if (m_close) begin
        m_rr = (m_rr + 1) % N; m_pend = '0; m_busy = 1'b0; m_close = 1'b0;
      end else begin
        last = (m_age == W - 1);
        if (m_cur < 0) begin
          if (!last) begin
            f = -1;
            for (int k = 0; k < N; k++)
              if (f < 0 && m_pend[(m_rr + k) % N]) f = (m_rr + k) % N;
            if (f >= 0) begin m_cur = f; m_hold = 0; end
            else m_close = 1'b1;
          end
        end else begin
          if (done[m_cur]) begin
            m_pend[m_cur] = 1'b0; m_cur = -1;
          end else if (m_hold == T - 1) begin
            m_err[m_cur] = 1'b1; m_pend[m_cur] = 1'b0; m_cur = -1;
          end else begin
            m_hold++;
          end
        end
        if (last) begin
          if (m_pend != 0) m_ovr = 1'b1;
          m_cur = -1; m_close = 1'b1;
        end
        m_age++;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_close = 0; m_vs = 0; m_ovr = 0;
      m_cur = -1; m_hold = 0; m_age = 0; m_rr = 0;
      m_fcnt = '0; m_pend = '0; m_err = '0;
    end else begin
      model_step();
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("grant", 16'(grant), 16'(m_grant()));
      check("busy", 16'(busy), 16'(m_busy));
      check("frame_cnt", frame_cnt, m_fcnt);
      check("overrun", 16'(overrun), 16'(m_ovr));
      check("timeout_err", 16'(timeout_err), 16'(m_err));
      check("wrap_frame_cnt", 16'(frame_cnt_w), 16'(m_fcnt[1:0]));
      check("wrap_grant", 16'(grant_w), 16'(m_grant()));
    end
  end

  // ---------------- clients and monitor ----------------
  int         dly [4];
  int         c_cnt [4];
  logic [3:0] gq [$];
  logic [3:0] g_last = '0;
  int         ovr_n = 0;
  int         h2 = 0;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (grant[i]) c_cnt[i]++;
      else c_cnt[i] = 0;
      done[i] = (dly[i] != 0) && grant[i] && (c_cnt[i] == dly[i]);
    end
    if (rst_n) begin
      if (grant != 0 && grant != g_last) gq.push_back(grant);
      g_last = grant;
      if (overrun) ovr_n++;
      if (grant == 4'b0100) h2++;
    end
  end

  function automatic logic [3:0] gat(input int k);
    if (k < gq.size()) return gq[k];
    return 4'hx;
  endfunction

  task automatic clear_obs();
    gq.delete(); ovr_n = 0; h2 = 0;
  endtask

  task automatic tick_frame(input logic [3:0] r);
    @(negedge clk); req = r; vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    repeat (2) @(negedge clk);
    while (busy === 1'b1 && k < 300) begin @(negedge clk); k++; end
    check({"idle_", name}, 16'(k >= 300), 16'd0);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin dly[i] = 0; c_cnt[i] = 0; end
    repeat (3) @(negedge clk);
    check("rst_grant", 16'(grant), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_overrun", 16'(overrun), 16'd0);
    check("rst_timeout_err", 16'(timeout_err), 16'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: two clients, done after 3 cycles
    dly[0] = 3; dly[2] = 3; clear_obs();
    tick_frame(4'b0101);
    check("t1_lat_scan", 16'(grant), 16'd0);
    @(negedge clk);
    check("t1_lat_grant", 16'(grant), 16'b0001);
    wait_idle("t1");
    check("t1_n", 16'(gq.size()), 16'd2);
    check("t1_g0", 16'(gat(0)), 16'b0001);
    check("t1_g1", 16'(gat(1)), 16'b0100);
    check("t1_fcnt", frame_cnt, 16'd1);
    check("t1_busy", 16'(busy), 16'd0);
    check("t1_ovr", 16'(ovr_n), 16'd0);

    // 2: rotated start
    clear_obs();
    tick_frame(4'b0101);
    wait_idle("t2");
    check("t2_g0", 16'(gat(0)), 16'b0100);
    check("t2_g1", 16'(gat(1)), 16'b0001);
    check("t2_fcnt", frame_cnt, 16'd2);

    // 3: client 2 times out
    dly[2] = 0; clear_obs();
    tick_frame(4'b0101);
    wait_idle("t3");
    check("t3_g0", 16'(gat(0)), 16'b0100);
    check("t3_g1", 16'(gat(1)), 16'b0001);
    check("t3_hold", 16'(h2), 16'd16);
    check("t3_err", 16'(timeout_err), 16'b0100);
    pulse_err_clr();
    check("t3_err_clr", 16'(timeout_err), 16'd0);

    // 4: all stall, window expires during 4th grant
    dly[0] = 0; clear_obs();
    tick_frame(4'b1111);
    wait_idle("t4");
    check("t4_n", 16'(gq.size()), 16'd4);
    check("t4_g0", 16'(gat(0)), 16'b1000);
    check("t4_g3", 16'(gat(3)), 16'b0100);
    check("t4_ovr", 16'(ovr_n), 16'd1);
    check("t4_err", 16'(timeout_err), 16'b1011);
    pulse_err_clr();

    // 5: last done lands on window end and on the TIMEOUT-1 cycle
    dly[0] = 0; dly[1] = 0; dly[2] = 12; dly[3] = 16; clear_obs();
    tick_frame(4'b1111);
    wait_idle("t5");
    check("t5_n", 16'(gq.size()), 16'd4);
    check("t5_g3", 16'(gat(3)), 16'b1000);
    check("t5_ovr", 16'(ovr_n), 16'd0);
    check("t5_err", 16'(timeout_err), 16'b0011);

    // 6: second vsync edge while busy
    dly[0] = 10; dly[1] = 0; dly[2] = 0; dly[3] = 0; clear_obs();
    tick_frame(4'b0001);
    repeat (3) @(negedge clk);
    tick_frame(4'b0001);
    wait_idle("t6");
    check("t6_ovr", 16'(ovr_n), 16'd1);
    check("t6_fcnt", frame_cnt, 16'd6);
    check("t6_wrap", 16'(frame_cnt_w), 16'd2);
    check("t6_n", 16'(gq.size()), 16'd1);

    // 7: async reset in the middle of a grant
    dly[0] = 0;
    tick_frame(4'b0001);
    repeat (3) @(negedge clk);
    check("t7_pre", 16'(grant), 16'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("t7_grant", 16'(grant), 16'd0);
    check("t7_busy", 16'(busy), 16'd0);
    check("t7_fcnt", frame_cnt, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    dly[0] = 3; clear_obs();
    tick_frame(4'b0001);
    wait_idle("t7");
    check("t7_after_fcnt", frame_cnt, 16'd1);
    check("t7_after_g0", 16'(gat(0)), 16'b0001);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
